// File: rtl/array_3_arbiter.sv
// array_3_arbiter
//   Shares a single-port cache data array between two requesters.
//   After reset it walks every address writing zeros, then grants at most
//   one access per cycle with round-robin priority.  Read data comes back
//   RD_LAT cycles after acceptance, tagged with the requesting port.
//
// Ports
//   clock, reset              : clock and asynchronous active-high reset
//   reqN_valid/ready          : request handshake for port N (0 = refill/writeback, 1 = CPU)
//   reqN_write/addr/wdata/wmask : request payload for port N
//   rsp0_valid, rsp1_valid    : one-cycle read response strobes per port
//   rsp_data                  : read data shared by both ports (valid only with a strobe)
//   init_done                 : high once the zero-fill has completed
//   mem_*                     : single-port array interface (mem_rdata is the array output)
module array_3_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 256,
    parameter int MASK_W = 4,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic [MASK_W-1:0] req0_wmask,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic [MASK_W-1:0] req1_wmask,

    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp_data,

    output logic              init_done,

    output logic              mem_en,
    output logic              mem_wmode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                rr_last_q, rr_last_d;
    logic                init_done_q, init_done_d;

    // Read-tracking shift register: entry 0 is loaded on acceptance,
    // entry RD_LAT-1 lines up with the array output.
    logic [RD_LAT-1:0]   rd_vld_q, rd_vld_d;
    logic [RD_LAT-1:0]   rd_port_q, rd_port_d;

    logic                run;
    logic                grant;
    logic                accept;
    logic                grant_write;

    assign run = (state_q == ST_RUN);

    // Round-robin: a lone requester always wins; on contention the port
    // that did not win last time is chosen.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && !req1_valid) begin
            grant = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant = 1'b1;
        end else if (req0_valid && req1_valid) begin
            grant = ~rr_last_q;
        end
    end

    assign req0_ready  = run && req0_valid && (grant == 1'b0);
    assign req1_ready  = run && req1_valid && (grant == 1'b1);
    assign accept      = req0_ready || req1_ready;
    assign grant_write = grant ? req1_write : req0_write;

    // Array drive.  During INIT the enable is masked by reset so the array
    // sees no access while reset is held.
    always_comb begin
        mem_en    = 1'b0;
        mem_wmode = 1'b0;
        mem_addr  = cnt_q;
        mem_wdata = '0;
        mem_wmask = '1;
        if (state_q == ST_INIT) begin
            mem_en    = ~reset;
            mem_wmode = ~reset;
        end else begin
            mem_addr  = grant ? req1_addr  : req0_addr;
            mem_wdata = grant ? req1_wdata : req0_wdata;
            mem_wmask = grant ? req1_wmask : req0_wmask;
            if (accept) begin
                mem_en    = 1'b1;
                mem_wmode = grant_write;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_last_d   = rr_last_q;
        init_done_d = init_done_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == {ADDR_W{1'b1}}) begin
                state_d     = ST_RUN;
                init_done_d = 1'b1;
            end
        end else if (accept) begin
            rr_last_d = grant;
        end
    end

    always_comb begin
        rd_vld_d     = rd_vld_q;
        rd_port_d    = rd_port_q;
        rd_vld_d[0]  = accept && !grant_write;
        rd_port_d[0] = grant;
        for (int i = 1; i < RD_LAT; i++) begin
            rd_vld_d[i]  = rd_vld_q[i-1];
            rd_port_d[i] = rd_port_q[i-1];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            rr_last_q   <= 1'b1;
            init_done_q <= 1'b0;
            rd_vld_q    <= '0;
            rd_port_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_last_q   <= rr_last_d;
            init_done_q <= init_done_d;
            rd_vld_q    <= rd_vld_d;
            rd_port_q   <= rd_port_d;
        end
    end

    // Response stage boundary: tag from the tail of the tracking register.
    assign rsp0_valid = rd_vld_q[RD_LAT-1] && !rd_port_q[RD_LAT-1];
    assign rsp1_valid = rd_vld_q[RD_LAT-1] &&  rd_port_q[RD_LAT-1];
    assign rsp_data   = mem_rdata;
    assign init_done  = init_done_q;

endmodule

// File: tb/tb_array_3_arbiter.sv
module tb_array_3_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 256;
    localparam int MASK_W = 4;
    localparam int RD_LAT = 1;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int LANE_W = DATA_W / MASK_W;

    logic              clock;
    logic              reset;
    logic              req0_valid, req0_ready, req0_write;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic [MASK_W-1:0] req0_wmask;
    logic              req1_valid, req1_ready, req1_write;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic [MASK_W-1:0] req1_wmask;
    logic              rsp0_valid, rsp1_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              init_done;
    logic              mem_en, mem_wmode;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic [DATA_W-1:0] mem_rdata;

    int vectors;
    int miscompares;
    int cyc;

    array_3_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .RD_LAT(RD_LAT)
    ) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_wmask(req0_wmask),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_wmask(req1_wmask),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
        .init_done(init_done),
        .mem_en(mem_en), .mem_wmode(mem_wmode), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Single-port array with a registered read port (RD_LAT = 1).
    logic [DATA_W-1:0] mem_arr [DEPTH];
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_wmode) begin
                for (int l = 0; l < MASK_W; l++)
                    if (mem_wmask[l]) mem_arr[mem_addr][l*LANE_W +: LANE_W] <= mem_wdata[l*LANE_W +: LANE_W];
            end else begin
                mem_rdata <= mem_arr[mem_addr];
            end
        end
    end

    // Scoreboard: the bench's own view of the array contents, and the
    // queue of responses it expects.
    typedef struct {
        logic              port;
        logic [DATA_W-1:0] data;
        int                due;
    } rsp_t;

    rsp_t              exp_q[$];
    logic [DATA_W-1:0] shadow [DEPTH];

    always begin
        rsp_t e;
        @(posedge clock);
        #4;
        cyc++;
        if (reset) begin
            exp_q.delete();
            for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
            vectors++;
            if (rsp0_valid || rsp1_valid) begin
                miscompares++;
                $display("FAIL rsp_in_reset got rsp0=%b rsp1=%b want 0 0", rsp0_valid, rsp1_valid);
            end
        end else begin
            if (rsp0_valid || rsp1_valid) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rsp_unexpected cyc=%0d rsp0=%b rsp1=%b want none", cyc, rsp0_valid, rsp1_valid);
                end else begin
                    e = exp_q.pop_front();
                    if (rsp0_valid === rsp1_valid || rsp1_valid !== e.port || rsp_data !== e.data || e.due != cyc) begin
                        miscompares++;
                        $display("FAIL rsp_sb cyc=%0d got rsp0=%b rsp1=%b data=%h want port=%0d data=%h due=%0d",
                                 cyc, rsp0_valid, rsp1_valid, rsp_data, e.port, e.data, e.due);
                    end
                end
            end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL rsp_missing cyc=%0d got no rsp want port=%0d due=%0d", cyc, exp_q[0].port, exp_q[0].due);
                void'(exp_q.pop_front());
            end
            if (req0_ready && req1_ready) begin
                vectors++;
                miscompares++;
                $display("FAIL dual_ready cyc=%0d got ready0=1 ready1=1 want at most one", cyc);
            end
            if (req0_valid && req0_ready) begin
                if (req0_write) begin
                    for (int l = 0; l < MASK_W; l++)
                        if (req0_wmask[l]) shadow[req0_addr][l*LANE_W +: LANE_W] = req0_wdata[l*LANE_W +: LANE_W];
                end else begin
                    exp_q.push_back('{port: 1'b0, data: shadow[req0_addr], due: cyc + RD_LAT});
                end
            end else if (req1_valid && req1_ready) begin
                if (req1_write) begin
                    for (int l = 0; l < MASK_W; l++)
                        if (req1_wmask[l]) shadow[req1_addr][l*LANE_W +: LANE_W] = req1_wdata[l*LANE_W +: LANE_W];
                end else begin
                    exp_q.push_back('{port: 1'b1, data: shadow[req1_addr], due: cyc + RD_LAT});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0; req0_wmask = '0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0; req1_wmask = '0;
    endtask

    // Present one request and hold it until accepted (bounded), then drop it.
    task automatic issue(input logic p, input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
        int n;
        if (p == 1'b0) begin
            req0_valid = 1'b1; req0_write = wr; req0_addr = a; req0_wdata = d; req0_wmask = m;
        end else begin
            req1_valid = 1'b1; req1_write = wr; req1_addr = a; req1_wdata = d; req1_wmask = m;
        end
        n = 0;
        #3;
        while (!(p ? req1_ready : req0_ready) && n < 20) begin
            @(posedge clock);
            #4;
            n++;
        end
        vectors++;
        if (!(p ? req1_ready : req0_ready)) begin
            miscompares++;
            $display("FAIL accept_timeout port=%0d addr=%h got ready=0 want 1", p, a);
        end
        tick();
        idle();
    endtask

    // Reset held for two cycles with outputs checked, released just after an edge.
    task automatic test_reset();
        reset = 1'b1;
        idle();
        tick();
        tick();
        #3;
        vectors++;
        if ({init_done, req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_en, mem_wmode} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got %b want 0000000",
                     {init_done, req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_en, mem_wmode});
        end
        tick();
        reset = 1'b0;
    endtask

    // Full zero-fill sequence; optionally port 1 starts a read of 0x123 at cycle hold_at.
    task automatic test_init(input int hold_at);
        for (int c = 1; c <= DEPTH; c++) begin
            if (hold_at != 0 && c == hold_at) begin
                req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 12'h123; req1_wmask = 4'hF;
            end
            #3;
            vectors++;
            if (mem_en !== 1'b1 || mem_wmode !== 1'b1 || mem_addr !== ADDR_W'(c - 1) || mem_wdata !== '0 ||
                mem_wmask !== 4'hF || init_done !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL init_cycle c=%0d got en=%b wm=%b addr=%h wd0=%b mask=%h done=%b rdy=%b%b want 1 1 %h 1 f 0 00",
                         c, mem_en, mem_wmode, mem_addr, (mem_wdata == '0), mem_wmask, init_done,
                         req0_ready, req1_ready, ADDR_W'(c - 1));
            end
            tick();
        end
        #3;
        vectors++;
        if (init_done !== 1'b1) begin
            miscompares++;
            $display("FAIL init_done_rise got %b want 1", init_done);
        end
        if (hold_at != 0) begin
            vectors++;
            if (req1_ready !== 1'b1 || mem_en !== 1'b1 || mem_wmode !== 1'b0 || mem_addr !== 12'h123) begin
                miscompares++;
                $display("FAIL held_req_accept got rdy=%b en=%b wm=%b addr=%h want 1 1 0 123",
                         req1_ready, mem_en, mem_wmode, mem_addr);
            end
            tick();
            idle();
            #3;
            vectors++;
            if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp_data !== '0) begin
                miscompares++;
                $display("FAIL held_req_rsp got rsp0=%b rsp1=%b data=%h want 0 1 0", rsp0_valid, rsp1_valid, rsp_data);
            end
            tick();
        end else begin
            vectors++;
            if (mem_en !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_after_init got mem_en=%b want 0", mem_en);
            end
            tick();
        end
    endtask

    task automatic test_read_zero();
        issue(1'b0, 1'b0, 12'h123, '0, 4'hF);
        #3;
        vectors++;
        if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp_data !== '0) begin
            miscompares++;
            $display("FAIL read_zero got rsp0=%b rsp1=%b data=%h want 1 0 0", rsp0_valid, rsp1_valid, rsp_data);
        end
        tick();
    endtask

    task automatic test_write_read();
        logic [DATA_W-1:0] d;
        d = {8{32'hA5A5_0001}};
        issue(1'b0, 1'b1, 12'h010, d, 4'hF);
        issue(1'b1, 1'b0, 12'h010, '0, 4'h0);
        #3;
        vectors++;
        if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp_data !== d) begin
            miscompares++;
            $display("FAIL write_read got rsp0=%b rsp1=%b data=%h want 0 1 %h", rsp0_valid, rsp1_valid, rsp_data, d);
        end
        tick();
        #3;
        vectors++;
        if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL write_read_single got rsp0=%b rsp1=%b want 0 0", rsp0_valid, rsp1_valid);
        end
        tick();
    endtask

    task automatic test_partial_write();
        logic [DATA_W-1:0] d, e;
        d = {4{64'h0123_4567_89AB_CDEF}};
        e = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF};
        issue(1'b0, 1'b1, 12'h020, {DATA_W{1'b1}}, 4'hF);
        issue(1'b0, 1'b1, 12'h020, d, 4'b0101);
        issue(1'b1, 1'b0, 12'h020, '0, 4'b0000);
        #3;
        vectors++;
        if (rsp1_valid !== 1'b1 || rsp_data !== e) begin
            miscompares++;
            $display("FAIL partial_write got rsp1=%b data=%h want 1 %h", rsp1_valid, rsp_data, e);
        end
        tick();
    endtask

    task automatic test_arbitration();
        logic [DATA_W-1:0] d1, d2, ed;
        logic [1:0]        er;
        d1 = {8{32'h0000_0001}};
        d2 = {8{32'h0000_0002}};
        issue(1'b1, 1'b1, 12'h001, d1, 4'hF);
        issue(1'b1, 1'b1, 12'h002, d2, 4'hF);
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 12'h001; req0_wmask = 4'hA;
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 12'h002; req1_wmask = 4'h5;
        for (int k = 0; k <= 4; k++) begin
            #3;
            if (k < 4) begin
                er = (k % 2 == 0) ? 2'b10 : 2'b01;
                vectors++;
                if ({req0_ready, req1_ready} !== er) begin
                    miscompares++;
                    $display("FAIL rr_grant k=%0d got ready=%b want %b", k, {req0_ready, req1_ready}, er);
                end
            end
            if (k > 0) begin
                er = ((k - 1) % 2 == 0) ? 2'b10 : 2'b01;
                ed = ((k - 1) % 2 == 0) ? d1 : d2;
                vectors++;
                if ({rsp0_valid, rsp1_valid} !== er || rsp_data !== ed) begin
                    miscompares++;
                    $display("FAIL rr_rsp k=%0d got rsp=%b data=%h want %b %h",
                             k, {rsp0_valid, rsp1_valid}, rsp_data, er, ed);
                end
            end
            tick();
            if (k == 3) idle();
        end
    endtask

    task automatic test_reset_mid_init();
        test_reset();
        for (int c = 1; c <= 2000; c++) begin
            #3;
            vectors++;
            if (mem_addr !== ADDR_W'(c - 1) || mem_en !== 1'b1) begin
                miscompares++;
                $display("FAIL pre_reset_init c=%0d got addr=%h en=%b want %h 1", c, mem_addr, mem_en, ADDR_W'(c - 1));
            end
            tick();
        end
        reset = 1'b1;
        #3;
        vectors++;
        if (init_done !== 1'b0 || mem_en !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_init_reset got done=%b en=%b want 0 0", init_done, mem_en);
        end
        tick();
        reset = 1'b0;
        test_init(0);
    endtask

    task automatic test_reset_mid_run();
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 12'h010; req0_wmask = 4'hF;
        #3;
        vectors++;
        if (req0_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL run_read_ready got %b want 1", req0_ready);
        end
        tick();
        reset = 1'b1;
        idle();
        #3;
        vectors++;
        if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || init_done !== 1'b0) begin
            miscompares++;
            $display("FAIL run_reset_drop got rsp0=%b rsp1=%b done=%b want 0 0 0", rsp0_valid, rsp1_valid, init_done);
        end
        tick();
        tick();
        reset = 1'b0;
        #3;
        vectors++;
        if (mem_addr !== '0 || mem_en !== 1'b1 || init_done !== 1'b0) begin
            miscompares++;
            $display("FAIL init_restart got addr=%h en=%b done=%b want 000 1 0", mem_addr, mem_en, init_done);
        end
        for (int i = 0; i < 6; i++) tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        reset       = 1'b1;
        idle();
        test_reset();
        test_init(0);
        test_read_zero();
        test_write_read();
        test_partial_write();
        test_arbitration();
        test_reset();
        test_init(100);
        test_reset_mid_init();
        test_reset_mid_run();
        #3;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/array_3_arbiter.md
Name: array_3_arbiter

Overview:
- Sits in front of the 4096 x 256-bit single-port cache data array and shares it between two requesters: port 0 (refill/writeback) and port 1 (CPU-side access).
- After reset it zero-initialises every entry.
- It then grants at most one access per cycle, using round-robin arbitration.
- It returns read data with a fixed latency and tags the response with the requesting port.

Parameters:
- ADDR_W, 12, array address width; depth = 2^ADDR_W.
- DATA_W, 256, data width.
- MASK_W, 4, write-mask width; one bit per DATA_W/MASK_W-bit lane.
- RD_LAT, 1, array read latency in cycles; legal values are 1 or 2.

Ports:
- clock  in  1  sole clock; also drives the array clock.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_write  in  1  1 = write, 0 = read.
- req0_addr  in  ADDR_W  port 0 address.
- req0_wdata  in  DATA_W  port 0 write data.
- req0_wmask  in  MASK_W  port 0 lane write enables.
- req1_valid, req1_ready, req1_write, req1_addr, req1_wdata, req1_wmask  same directions, widths and meanings as port 0, for port 1.
- rsp0_valid  out  1  read data valid for port 0.
- rsp1_valid  out  1  read data valid for port 1.
- rsp_data  out  DATA_W  read data; shared by both ports.
- init_done  out  1  high once initialisation has completed.
- mem_en  out  1  array enable.
- mem_wmode  out  1  array write mode.
- mem_addr  out  ADDR_W  array address.
- mem_wdata  out  DATA_W  array write data.
- mem_wmask  out  MASK_W  array write mask.
- mem_rdata  in  DATA_W  array read data.

Behaviour:
- Reset values (asynchronous, active-high):
  - state = INIT; init counter = 0; rr_last = 1, so port 0 wins first.
  - Response pipeline cleared.
  - Outputs low: init_done, req*_ready, rsp*_valid, mem_en, mem_wmode.
  - rsp_data follows mem_rdata; its value is don't-care when no rsp*_valid is high.
- INIT state:
  - Each cycle: mem_en=1, mem_wmode=1, mem_addr=counter, mem_wdata=0, mem_wmask=all ones; counter increments.
  - req*_ready=0 throughout.
  - When the write to address 2^ADDR_W-1 is issued: next state = RUN, and init_done rises the following cycle.
  - Initialisation takes exactly 2^ADDR_W cycles (4096 at defaults).
- RUN state arbitration (combinational):
  - Only one valid request: that port is granted.
  - Both valid: the port not equal to rr_last is granted.
  - reqN_ready = RUN && grant==N; at most one ready is high per cycle.
  - A request is accepted when valid && ready. Ready may depend on valid, and is not required to hold in the absence of valid.
- Accepted request, same cycle:
  - mem_en=1, mem_wmode=req_write.
  - mem_addr, mem_wdata and mem_wmask are driven from the granted port.
  - rr_last <= grant.
- No accepted request: mem_en=0 and mem_wmode=0.
- Reads:
  - An accepted read at cycle t asserts rspN_valid for exactly one cycle at t+RD_LAT, with rsp_data = mem_rdata in that cycle.
  - Tracking uses an RD_LAT-deep shift register of {valid, port}.
  - Back-to-back reads produce back-to-back responses, in issue order.
- Writes produce no response.
- There is no response backpressure; requesters must always sink responses.
- Ordering: a read accepted the cycle after a write to the same address returns the newly written data in the unmasked lanes and the old data in the masked lanes.
- wmask is ignored for reads.
- Reset asserted mid-INIT or mid-RUN:
  - Initialisation restarts from address 0.
  - In-flight read responses are dropped; no rsp*_valid is produced for them.
- Requests presented during INIT are held off (ready=0), not lost, as long as the requester keeps valid asserted.

Test Plan:
- Reset, no requests -> mem_en=1 and mem_wmode=1 for 4096 consecutive cycles, addresses 0..4095, wdata=0, wmask=4'hF; init_done=1 on cycle 4097; a read of address 0x123 afterwards returns all zeros.
- After init, port 0 writes addr 0x010 data {8{32'hA5A5_0001}} mask 4'hF; next cycle port 1 reads 0x010 -> rsp1_valid exactly 1 cycle after the read is accepted, rsp_data = written value, rsp0_valid=0.
- Both ports hold valid with reads to 0x001 (port 0) and 0x002 (port 1) for 4 cycles -> grants alternate 0,1,0,1; responses alternate port tags with the matching data.
- Partial write to 0x020, mask 4'b0101 over a previously all-ones entry -> read-back = lanes 0 and 2 new data, lanes 1 and 3 all ones.
- Port 1 asserts valid during INIT at cycle 100 -> req1_ready stays 0 until the first RUN cycle, then is accepted; no array access is issued for it before init_done.
- Reset pulsed at cycle 2000 of INIT, and again one cycle after an accepted read in RUN -> counter restarts at 0, init_done low; the dropped read produces no rsp*_valid.
